// File: rtl/n64_pkg.sv
// Shared types for the n64 memory bridge: FSM states and bank decode helpers.
package n64_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HI,
    LO,
    DONE,
    LOCAL
  } state_t;

  localparam int BANK_W = 4;
  localparam int N_BANKS = 16;
  localparam logic [BANK_W-1:0] BANK_LOCAL = 4'd0;

  function automatic logic bank_enabled(input logic [N_BANKS-1:0] mask,
                                        input logic [BANK_W-1:0]  bank);
    return mask[bank];
  endfunction

endpackage

// File: rtl/n64_mem_bridge_if.sv
// PI-side request bus and cartridge memory port of the n64 memory bridge.
interface n64_mem_bridge_if;
  logic        i_request;
  logic        i_write;
  logic [3:0]  i_bank;
  logic [25:0] i_address;
  logic [31:0] i_data;
  logic        o_busy;
  logic        o_ack;
  logic [31:0] o_data;
  logic        o_mem_request;
  logic        o_mem_write;
  logic [24:0] o_mem_address;
  logic [15:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic        o_timeout;

  modport slave (
    input  i_request, i_write, i_bank, i_address, i_data, i_mem_ack, i_mem_rdata,
    output o_busy, o_ack, o_data, o_mem_request, o_mem_write, o_mem_address,
           o_mem_wdata, o_timeout
  );

  modport master (
    output i_request, i_write, i_bank, i_address, i_data, i_mem_ack, i_mem_rdata,
    input  o_busy, o_ack, o_data, o_mem_request, o_mem_write, o_mem_address,
           o_mem_wdata, o_timeout
  );
endinterface

// File: rtl/n64_mem_bridge_timer.sv
// Per-phase timeout down-counter; expires on the TIMEOUT_CYCLES-th cycle without ack.
module n64_mem_bridge_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt <= CNT_LOAD;
    end else if (i_clear) begin
      cnt <= CNT_LOAD;
    end else if (i_run && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign o_expired = i_run && (cnt == '0);
endmodule

// File: rtl/n64_mem_bridge.sv
// 32-bit PI word requests split into two 16-bit memory phases, high halfword first.
// Optional phase timeout: define N64_MEM_BRIDGE_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a request
// HI    | high halfword phase, address bit 0 = 0
// LO    | low halfword phase, address bit 0 = 1
// DONE  | word complete, read ack pulse, may accept next request
// LOCAL | unmapped bank, completes without memory access
module n64_mem_bridge
  import n64_pkg::*;
#(
  parameter logic [15:0] BANK_ENABLE_MASK = 16'hFFFE,
  parameter int          TIMEOUT_CYCLES   = 255
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  n64_mem_bridge_if.slave  bus
);
  state_t      state, next_state;
  logic        accept;
  logic        phase;
  logic        expired;
  logic [23:0] addr_q;
  logic        wr_q;
  logic [31:0] data_q;
  logic        busy_q;
  logic        ack_q;
  logic        timeout_q;
  logic [31:0] odata_q;

  assign phase = (state == HI) || (state == LO);

`ifdef N64_MEM_BRIDGE_TIMEOUT_EN
  n64_mem_bridge_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (accept || (state == HI && bus.i_mem_ack)),
    .i_run     (phase && !bus.i_mem_ack),
    .o_expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE, DONE: begin
        next_state = IDLE;
        if (bus.i_request && !busy_q) begin
          accept     = 1'b1;
          next_state = bank_enabled(BANK_ENABLE_MASK, bus.i_bank) ? HI : LOCAL;
        end
      end
      HI:      if (bus.i_mem_ack) next_state = LO;
               else if (expired)  next_state = DONE;
      LO:      if (bus.i_mem_ack || expired) next_state = DONE;
      LOCAL:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr_q    <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      odata_q   <= '0;
    end else begin
      ack_q     <= 1'b0;
      timeout_q <= 1'b0;
      if (accept) begin
        addr_q <= bus.i_address[25:2];
        wr_q   <= bus.i_write;
        data_q <= bus.i_data;
        busy_q <= 1'b1;
      end
      // Reads reuse the unused write-data register to hold the high halfword.
      if (state == HI && bus.i_mem_ack && !wr_q) data_q[31:16] <= bus.i_mem_rdata;
      if (state == LO && bus.i_mem_ack) begin
        busy_q <= 1'b0;
        if (!wr_q) begin
          ack_q   <= 1'b1;
          odata_q <= {data_q[31:16], bus.i_mem_rdata};
        end
      end else if (phase && expired) begin
        busy_q    <= 1'b0;
        timeout_q <= 1'b1;
        if (!wr_q) begin
          ack_q   <= 1'b1;
          odata_q <= 32'hFFFF_FFFF;
        end
      end
      if (state == LOCAL) begin
        busy_q <= 1'b0;
        if (!wr_q) begin
          ack_q   <= 1'b1;
          odata_q <= 32'h0000_0000;
        end
      end
    end
  end

  assign bus.o_busy        = busy_q;
  assign bus.o_ack         = ack_q;
  assign bus.o_data        = odata_q;
  assign bus.o_timeout     = timeout_q;
  assign bus.o_mem_request = phase;
  assign bus.o_mem_write   = phase && wr_q;
  assign bus.o_mem_address = phase ? {addr_q, state == LO} : 25'd0;
  assign bus.o_mem_wdata   = (state == HI) ? data_q[31:16] :
                             (state == LO) ? data_q[15:0]  : 16'd0;
endmodule

// File: tb/tb_n64_mem_bridge.sv
// Directed bench for n64_mem_bridge with a behavioural cartridge memory.
module tb_n64_mem_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  n64_mem_bridge_if bus();

  n64_mem_bridge #(
    .BANK_ENABLE_MASK(16'hFFFE),
    .TIMEOUT_CYCLES  (4)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory model: acks after mem_wait idle cycles of a held request
  int          mem_wait = 0;
  int          wcnt     = 0;
  logic        mem_en   = 1'b1;
  logic [15:0] rq[$];
  logic [24:0] log_addr[$];
  logic [15:0] log_wd[$];
  logic        log_wr[$];
  int          to_pulses = 0;

  always @(negedge clk) begin
    bus.i_mem_ack = 1'b0;
    if (bus.o_timeout) to_pulses++;
    if (bus.o_mem_request && mem_en) begin
      if (wcnt >= mem_wait) begin
        bus.i_mem_ack   = 1'b1;
        bus.i_mem_rdata = (rq.size() > 0) ? rq.pop_front() : 16'h0000;
        log_addr.push_back(bus.o_mem_address);
        log_wd.push_back(bus.o_mem_wdata);
        log_wr.push_back(bus.o_mem_write);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  logic        busy_at[1:15];
  logic        req_at[1:15];
  logic [24:0] addr_at[1:15];
  int          ack_cnt, ack_first, busy_low, to_first;
  logic [31:0] data_at_ack;

  task automatic clear_logs();
    log_addr.delete();
    log_wd.delete();
    log_wr.delete();
  endtask

  task automatic pad_logs(input int n);
    while (log_addr.size() < n) begin
      log_addr.push_back('x);
      log_wd.push_back('x);
      log_wr.push_back(1'bx);
    end
  endtask

  task automatic start_req(input logic w, input logic [3:0] bank, input logic [25:0] addr,
                           input logic [31:0] data);
    @(negedge clk);
    bus.i_write   = w;
    bus.i_bank    = bank;
    bus.i_address = addr;
    bus.i_data    = data;
    bus.i_request = 1'b1;
    @(posedge clk);
    #1 bus.i_request = 1'b0;
  endtask

  task automatic run_window(input int ncyc);
    ack_cnt = 0; ack_first = -1; busy_low = -1; to_first = -1; data_at_ack = 'x;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      busy_at[n] = bus.o_busy;
      req_at[n]  = bus.o_mem_request;
      addr_at[n] = bus.o_mem_address;
      if (bus.o_ack) begin
        ack_cnt++;
        if (ack_first < 0) begin
          ack_first   = n;
          data_at_ack = bus.o_data;
        end
      end
      if (!bus.o_busy && busy_low < 0) busy_low = n;
      if (bus.o_timeout && to_first < 0) to_first = n;
    end
  endtask

  initial begin
    int ack_c[$];
    logic [31:0] ack_d[$];
    bus.i_request = 0; bus.i_write = 0; bus.i_bank = 0; bus.i_address = 0;
    bus.i_data = 0; bus.i_mem_ack = 0; bus.i_mem_rdata = 0;

    #12;
    check_val("rst_busy",   bus.o_busy,        0);
    check_val("rst_ack",    bus.o_ack,         0);
    check_val("rst_data",   bus.o_data,        0);
    check_val("rst_memreq", bus.o_mem_request, 0);
    check_val("rst_memadr", bus.o_mem_address, 0);
    check_val("rst_to",     bus.o_timeout,     0);
    @(negedge clk); rst_n = 1'b1;

    // zero-wait read, bank 1
    mem_wait = 0; clear_logs(); rq = '{16'hDEAD, 16'hBEEF};
    start_req(1'b0, 4'd1, 26'h0001004, 32'h0);
    run_window(5);
    check_val("rd_busy_c1", busy_at[1], 1);
    check_val("rd_req_c1",  req_at[1],  1);
    check_val("rd_adr_hi",  addr_at[1], 25'h0000802);
    check_val("rd_adr_lo",  addr_at[2], 25'h0000803);
    check_val("rd_req_c3",  req_at[3],  0);
    check_val("rd_ack_cyc", ack_first,  3);
    check_val("rd_ack_cnt", ack_cnt,    1);
    check_val("rd_busylow", busy_low,   3);
    check_val("rd_data",    data_at_ack, 32'hDEADBEEF);
    check_val("rd_phases",  log_addr.size(), 2);

    // write with two wait cycles per phase
    mem_wait = 2; clear_logs();
    start_req(1'b1, 4'd3, 26'h0002008, 32'h12345678);
    run_window(9);
    check_val("wr_busylow", busy_low, 7);
    check_val("wr_ack_cnt", ack_cnt,  0);
    check_val("wr_adr_c3",  addr_at[3], 25'h0001004);
    check_val("wr_adr_c4",  addr_at[4], 25'h0001005);
    check_val("wr_phases",  log_addr.size(), 2);
    pad_logs(2);
    check_val("wr_wd_hi",   log_wd[0], 16'h1234);
    check_val("wr_wd_lo",   log_wd[1], 16'h5678);
    check_val("wr_we_hi",   log_wr[0], 1);
    check_val("wr_we_lo",   log_wr[1], 1);
    check_val("wr_hold",    bus.o_data, 32'hDEADBEEF);

    // unmapped bank 0: write discarded, read returns zero
    mem_wait = 0; clear_logs();
    start_req(1'b1, 4'd0, 26'h0000010, 32'hCAFEF00D);
    run_window(4);
    check_val("uw_busy_c1", busy_at[1], 1);
    check_val("uw_busylow", busy_low,   2);
    check_val("uw_ack_cnt", ack_cnt,    0);
    check_val("uw_phases",  log_addr.size(), 0);
    check_val("uw_hold",    bus.o_data, 32'hDEADBEEF);
    start_req(1'b0, 4'd0, 26'h0000010, 32'h0);
    run_window(4);
    check_val("ur_busy_c1", busy_at[1], 1);
    check_val("ur_req_c1",  req_at[1],  0);
    check_val("ur_ack_cyc", ack_first,  2);
    check_val("ur_data",    data_at_ack, 32'h0);
    check_val("ur_phases",  log_addr.size(), 0);

    // back-to-back: second request held through busy
    clear_logs(); rq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    @(negedge clk);
    bus.i_write = 0; bus.i_bank = 4'd2; bus.i_address = 26'h0000100; bus.i_request = 1;
    @(posedge clk);
    #1 bus.i_address = 26'h0000204;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      busy_at[n] = bus.o_busy;
      addr_at[n] = bus.o_mem_address;
      if (bus.o_ack) begin
        ack_c.push_back(n);
        ack_d.push_back(bus.o_data);
      end
      if (n == 4) bus.i_request = 0;
    end
    while (ack_c.size() < 2) begin ack_c.push_back(-1); ack_d.push_back('x); end
    check_val("bb_ack_cnt", ack_c.size(), 2);
    check_val("bb_busy_c3", busy_at[3], 0);
    check_val("bb_busy_c4", busy_at[4], 1);
    check_val("bb_adr_c4",  addr_at[4], 25'h0000102);
    check_val("bb_ack1",    ack_c[0], 3);
    check_val("bb_ack2",    ack_c[1], 6);
    check_val("bb_data1",   ack_d[0], 32'h11112222);
    check_val("bb_data2",   ack_d[1], 32'h33334444);
    check_val("bb_phases",  log_addr.size(), 4);
    pad_logs(4);
    check_val("bb_adr_p0",  log_addr[0], 25'h0000080);
    check_val("bb_adr_p3",  log_addr[3], 25'h0000103);

    // asynchronous reset in the LO phase
    mem_wait = 3; clear_logs(); rq = '{16'hAAAA, 16'hBBBB};
    start_req(1'b0, 4'd1, 26'h0000040, 32'h0);
    run_window(5);
    check_val("ar_in_lo",   addr_at[5], 25'h0000021);
    check_val("ar_req_lo",  req_at[5],  1);
    #2 rst_n = 1'b0;
    #1;
    check_val("ar_memreq",  bus.o_mem_request, 0);
    check_val("ar_busy",    bus.o_busy, 0);
    check_val("ar_data",    bus.o_data, 0);
    check_val("ar_memadr",  bus.o_mem_address, 0);
    @(negedge clk); rst_n = 1'b1;
    mem_wait = 0; clear_logs(); rq = '{16'h5555, 16'h6666};
    start_req(1'b0, 4'd5, 26'h0000008, 32'h0);
    run_window(5);
    check_val("ar_rd_ack",  ack_first, 3);
    check_val("ar_rd_data", data_at_ack, 32'h55556666);
    check_val("ar_rd_adr",  addr_at[1], 25'h0000004);

`ifdef N64_MEM_BRIDGE_TIMEOUT_EN
    mem_en = 1'b0; clear_logs();
    start_req(1'b0, 4'd1, 26'h0000100, 32'h0);
    run_window(7);
    check_val("to_req_c4",  req_at[4], 1);
    check_val("to_cycle",   to_first, 5);
    check_val("to_ack_cyc", ack_first, 5);
    check_val("to_data",    data_at_ack, 32'hFFFFFFFF);
    check_val("to_busylow", busy_low, 5);
    check_val("to_req_c6",  req_at[6], 0);
    check_val("to_pulses",  to_pulses, 1);
    mem_en = 1'b1;
`else
    check_val("no_to_pulse", to_pulses, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
